// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register for the LEGv8 pipeline.
//   Owns the PC, presents it combinationally to instruction memory, and latches
//   the returned word together with its PC for the decode stage.
//
// Ports
//   clock             : rising-edge clock for all state
//   reset             : synchronous, active-low reset
//   stall             : hold PC and IF/ID this cycle (hazard unit)
//   branch_taken      : redirect PC to branch_target and flush IF/ID
//   branch_target     : redirect address (low two bits forced to zero)
//   im_data           : instruction word for im_address, same cycle
//   im_address        : current PC (combinational)
//   pc_plus4          : PC + 4, wraps modulo 2^64
//   if_id_pc          : PC of the instruction held in IF/ID
//   if_id_instruction : instruction held in IF/ID (opcode in [31:21])
//   if_id_valid       : IF/ID holds a real instruction rather than a bubble
//   misalign_fault    : sticky, set by a redirect with branch_target[1:0] != 0
//   fetch_count       : saturating count of valid loads into IF/ID
//   stall_count       : saturating count of stalled cycles
module if_id_fetch_stage #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter logic [31:0] NOP_INSTR   = 32'hD503201F,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [63:0]            branch_target,
  input  logic [31:0]            im_data,
  output logic [63:0]            im_address,
  output logic [63:0]            pc_plus4,
  output logic [63:0]            if_id_pc,
  output logic [31:0]            if_id_instruction,
  output logic                   if_id_valid,
  output logic                   misalign_fault,
  output logic [COUNT_WIDTH-1:0] fetch_count,
  output logic [COUNT_WIDTH-1:0] stall_count
);

  logic [63:0]            pc;
  logic [63:0]            pcNext4;
  logic [63:0]            ifIdPc;
  logic [31:0]            ifIdInstr;
  logic                   ifIdValid;
  logic                   misalignFlag;
  logic [COUNT_WIDTH-1:0] fetchCnt;
  logic [COUNT_WIDTH-1:0] stallCnt;

  always_comb begin
    pcNext4 = pc + 64'd4;
  end

  // Priority: reset > branch_taken > stall > normal fetch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc           <= RESET_PC;
      ifIdPc       <= '0;
      ifIdInstr    <= NOP_INSTR;
      ifIdValid    <= 1'b0;
      misalignFlag <= 1'b0;
      fetchCnt     <= '0;
      stallCnt     <= '0;
    end else if (branch_taken) begin
      // Redirect wins over a simultaneous stall; ifIdPc keeps its old value.
      pc        <= {branch_target[63:2], 2'b00};
      ifIdInstr <= NOP_INSTR;
      ifIdValid <= 1'b0;
      if (branch_target[1:0] != 2'b00) begin
        misalignFlag <= 1'b1;
      end
    end else if (stall) begin
      if (stallCnt != '1) begin
        stallCnt <= stallCnt + COUNT_WIDTH'(1);
      end
    end else begin
      pc        <= pcNext4;
      ifIdPc    <= pc;
      ifIdInstr <= im_data;
      ifIdValid <= 1'b1;
      if (fetchCnt != '1) begin
        fetchCnt <= fetchCnt + COUNT_WIDTH'(1);
      end
    end
  end

  assign im_address        = pc;
  assign pc_plus4          = pcNext4;
  assign if_id_pc          = ifIdPc;
  assign if_id_instruction = ifIdInstr;
  assign if_id_valid       = ifIdValid;
  assign misalign_fault    = misalignFlag;
  assign fetch_count       = fetchCnt;
  assign stall_count       = stallCnt;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// tb_if_id_fetch_stage
//   Scoreboard bench for if_id_fetch_stage. Instruction memory returns the low
//   32 bits of its address as the instruction word. A narrow counter width is
//   used so saturation is reachable in a short run.
module tb_if_id_fetch_stage;

  localparam int unsigned CW = 4;
  localparam logic [31:0] NOP = 32'hD503201F;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall;
  logic          branch_taken;
  logic [63:0]   branch_target;
  logic [31:0]   im_data;
  logic [63:0]   im_address;
  logic [63:0]   pc_plus4;
  logic [63:0]   if_id_pc;
  logic [31:0]   if_id_instruction;
  logic          if_id_valid;
  logic          misalign_fault;
  logic [CW-1:0] fetch_count;
  logic [CW-1:0] stall_count;

  always #5 clock = ~clock;

  assign im_data = im_address[31:0];

  if_id_fetch_stage #(
    .RESET_PC   (64'h0),
    .NOP_INSTR  (NOP),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .im_data          (im_data),
    .im_address       (im_address),
    .pc_plus4         (pc_plus4),
    .if_id_pc         (if_id_pc),
    .if_id_instruction(if_id_instruction),
    .if_id_valid      (if_id_valid),
    .misalign_fault   (misalign_fault),
    .fetch_count      (fetch_count),
    .stall_count      (stall_count)
  );

  typedef struct {
    logic [63:0]   pc;
    logic [63:0]   ifIdPc;
    logic [31:0]   instr;
    logic          valid;
    logic          mis;
    logic [CW-1:0] fc;
    logic [CW-1:0] sc;
  } expT;

  expT sbQ[$];

  int checks   = 0;
  int failures = 0;

  // Reference state, advanced as each stimulus cycle is issued.
  logic [63:0]   mPc     = '0;
  logic [63:0]   mIfIdPc = '0;
  logic [31:0]   mInstr  = NOP;
  logic          mValid  = 1'b0;
  logic          mMis    = 1'b0;
  logic [CW-1:0] mFc     = '0;
  logic [CW-1:0] mSc     = '0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic st, input logic br, input logic [63:0] tgt);
    expT e;
    reset         = rst;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    if (!rst) begin
      mPc = '0; mIfIdPc = '0; mInstr = NOP; mValid = 1'b0;
      mMis = 1'b0; mFc = '0; mSc = '0;
    end else if (br) begin
      mPc    = {tgt[63:2], 2'b00};
      mInstr = NOP;
      mValid = 1'b0;
      if (tgt[1:0] != 2'b00) mMis = 1'b1;
    end else if (st) begin
      if (mSc != {CW{1'b1}}) mSc = mSc + 1'b1;
    end else begin
      mIfIdPc = mPc;
      mInstr  = mPc[31:0];
      mValid  = 1'b1;
      mPc     = mPc + 64'd4;
      if (mFc != {CW{1'b1}}) mFc = mFc + 1'b1;
    end
    e.pc = mPc; e.ifIdPc = mIfIdPc; e.instr = mInstr; e.valid = mValid;
    e.mis = mMis; e.fc = mFc; e.sc = mSc;
    sbQ.push_back(e);
    @(posedge clock);
    #1;
    if (sbQ.size() == 0) begin
      checkVal("sb_empty", 64'd0, 64'd1);
    end else begin
      e = sbQ.pop_front();
      checkVal("im_address", im_address, e.pc);
      checkVal("pc_plus4", pc_plus4, e.pc + 64'd4);
      checkVal("if_id_pc", if_id_pc, e.ifIdPc);
      checkVal("if_id_instr", {32'd0, if_id_instruction}, {32'd0, e.instr});
      checkVal("if_id_valid", {63'd0, if_id_valid}, {63'd0, e.valid});
      checkVal("misalign", {63'd0, misalign_fault}, {63'd0, e.mis});
      checkVal("fetch_count", {60'd0, fetch_count}, {60'd0, e.fc});
      checkVal("stall_count", {60'd0, stall_count}, {60'd0, e.sc});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    #2;

    // Reset, then the first cycle shows RESET_PC with an empty IF/ID.
    cycle(1'b0, 1'b0, 1'b0, 64'h0);
    checkVal("rst_addr", im_address, 64'h0);
    checkVal("rst_valid", {63'd0, if_id_valid}, 64'd0);
    checkVal("rst_instr", {32'd0, if_id_instruction}, {32'd0, NOP});

    // Two free cycles.
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    checkVal("free_addr", im_address, 64'h8);
    checkVal("free_ifpc", if_id_pc, 64'h4);
    checkVal("free_instr", {32'd0, if_id_instruction}, 64'h4);
    checkVal("free_fc", {60'd0, fetch_count}, 64'd2);

    // Two stall cycles hold everything at pc 8.
    cycle(1'b1, 1'b1, 1'b0, 64'hDEAD);
    cycle(1'b1, 1'b1, 1'b0, 64'hBEEF);
    checkVal("stall_addr", im_address, 64'h8);
    checkVal("stall_ifpc", if_id_pc, 64'h4);
    checkVal("stall_sc", {60'd0, stall_count}, 64'd2);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    checkVal("release_ifpc", if_id_pc, 64'h8);
    checkVal("release_instr", {32'd0, if_id_instruction}, 64'h8);
    checkVal("release_fc", {60'd0, fetch_count}, 64'd3);

    // Branch together with stall: redirect wins, bubble, counters frozen.
    cycle(1'b1, 1'b1, 1'b1, 64'h100);
    checkVal("br_addr", im_address, 64'h100);
    checkVal("br_valid", {63'd0, if_id_valid}, 64'd0);
    checkVal("br_instr", {32'd0, if_id_instruction}, {32'd0, NOP});
    checkVal("br_ifpc_hold", if_id_pc, 64'h8);
    checkVal("br_fc", {60'd0, fetch_count}, 64'd3);
    checkVal("br_sc", {60'd0, stall_count}, 64'd2);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    checkVal("br_next_ifpc", if_id_pc, 64'h100);
    checkVal("br_next_instr", {32'd0, if_id_instruction}, 64'h100);

    // Misaligned target: aligned PC, sticky fault.
    cycle(1'b1, 1'b0, 1'b1, 64'h102);
    checkVal("mis_addr", im_address, 64'h100);
    checkVal("mis_flag", {63'd0, misalign_fault}, 64'd1);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h3);
    checkVal("mis_sticky", {63'd0, misalign_fault}, 64'd1);

    // PC wrap at the top of the address space.
    cycle(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    checkVal("wrap_plus4", pc_plus4, 64'h0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    checkVal("wrap_pc", im_address, 64'h0);
    checkVal("wrap_ifpc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Counter saturation.
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 64'h0);
    checkVal("fc_sat", {60'd0, fetch_count}, 64'd15);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    checkVal("fc_sat_hold", {60'd0, fetch_count}, 64'd15);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);
    checkVal("sc_sat", {60'd0, stall_count}, 64'd15);

    // Reset while stall and branch are both asserted.
    cycle(1'b0, 1'b1, 1'b1, 64'h206);
    checkVal("rst2_addr", im_address, 64'h0);
    checkVal("rst2_ifpc", if_id_pc, 64'h0);
    checkVal("rst2_mis", {63'd0, misalign_fault}, 64'd0);
    checkVal("rst2_fc", {60'd0, fetch_count}, 64'd0);
    checkVal("rst2_sc", {60'd0, stall_count}, 64'd0);

    // Back-to-back redirects keep IF/ID a bubble.
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b0, 1'b1, 64'h200);
    cycle(1'b1, 1'b0, 1'b1, 64'h300);
    cycle(1'b1, 1'b1, 1'b1, 64'h400);
    checkVal("b2b_addr", im_address, 64'h400);
    checkVal("b2b_valid", {63'd0, if_id_valid}, 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 64'h0);
    checkVal("b2b_instr", {32'd0, if_id_instruction}, 64'h400);

    checkVal("sb_drained", 64'(sbQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
